clk_tick_chain: RTL
===================

// Module: clk_tick_chain
// PURPOSE
//  Single-clock, parametrised cascade of N_CH divide stages producing one-cycle clock-enable
//  ticks (e.g. 100 MHz -> 1 kHz -> 1 Hz) instead of ripple-derived clocks.
//  Each stage's divisor is runtime-programmable with glitch-free, wrap-aligned update.
//  Feeds timers/FSMs (traffic-light phase counters) that run on clk and qualify with tick[k].
// PARAMETERS
//  N_CH      3                        number of cascaded stages (1..8)
//  CNT_W     17                       counter/divisor width per stage
//  RST_DIVS  {17'd1000,17'd1000,17'd100}  flat N_CH*CNT_W reset divisors; slice k = stage k (LSB = stage 0)
// PORTS
//  clk      in   1            system clock, all logic on posedge
//  rst      in   1            asynchronous reset, active-high
//  en       in   1            count enable for stage 0 (1 = count clk cycles)
//  sc       in   1            synchronous clear: zero all counters, suppress ticks this cycle
//  div_wr   in   1            divisor write strobe (one cycle)
//  div_sel  in   3            target stage index for div_wr
//  div_val  in   CNT_W        new divisor for div_sel
//  pend     out  N_CH         pend[k]=1: written divisor not yet active in stage k
//  tick     out  N_CH         tick[k]: one-cycle pulse each time stage k wraps
//  sq       out  N_CH         square outputs (only with CLK_TICK_SQ_EN, else tied 0)
// BEHAVIOUR
//  - Reset (rst=1, async): cnt[k]=0, active div[k]=shadow[k]=RST_DIVS slice k, pend=0, sq=0.
//  - Stage input: in[0]=en & ~sc; in[k]=tick[k-1] for k>0.
//  - term[k] = (div[k]==0) ? 0 : div[k]-1 (divisor 0 behaves as 1: tick on every input).
//  - tick[k] = in[k] & (cnt[k]==term[k]); combinational from registers, so all stages
//    wrapping together pulse in the same cycle (zero added latency down the chain).
//  - On clk edge, if in[k]: cnt[k] <= tick[k] ? 0 : cnt[k]+1. No input -> hold.
//  - Period of tick[k] = prod(div[0..k]) clk cycles with en held 1; first tick[0] after
//    reset/sc occurs div[0] cycles after en=1.
//  - Divisor write: div_wr with div_sel<N_CH loads shadow[div_sel] and sets pend[div_sel].
//    div_sel>=N_CH: ignored, no state change. Repeated writes before apply: last wins.
//  - Apply: on the edge where tick[k]=1, div[k] <= shadow[k], pend[k] <= 0. A write in the
//    same cycle as a wrap is applied in that cycle (div_val used directly).
//  - If cnt[k] > term of new divisor cannot arise (apply only at wrap, cnt restarts at 0).
//  - sc=1: all cnt<=0, tick=0, every div[k]<=shadow (or div_val if written same cycle),
//    pend<=0; sq unchanged. sc has priority over en and wraps.
//  - rst mid-count/mid-pending: everything returns to reset values; pending writes lost.
//  - en=0 freezes the whole chain (higher stages only move on lower ticks).
// CONFIGURATION
//  CLK_TICK_SQ_EN defined: sq[k] toggles on every tick[k] edge (50% duty at half tick
//    rate), cleared by rst only. Undefined: sq is constant 0 and no flops inferred.
// STRUCTURE
//  - Package clk_tick_pkg: CNT_W default, default reset divisors (1 kHz/1 Hz at 100 MHz),
//    MAX_CH=8, SEL_W=3.
//  - Sub-module clk_tick_stage (one counter + active/shadow divisor + pend + optional sq);
//    top generates N_CH instances and chains in/tick.
// TESTING
//  1 rst=1 then 0, en=1, divs {3,4,5}: tick[0] every 5 clk, tick[1] every 20, tick[2] every
//    60; first tick[2] at cycle 60, coincident with tick[1] and tick[0].
//  2 div_wr sel=0 val=2 at cycle 2 of a 5-period: pend[0]=1 until next tick[0] at cycle 5,
//    then periods of 2; pend[0]=0 after that edge.
//  3 sc pulse mid-count (cnt0=3) with pending div: no tick that cycle, counters 0, new
//    div active, next tick[0] exactly div[0] cycles later.
//  4 div=0 and div=1 on stage 0: tick[0]=en every cycle; en toggled 1/0: ticks only when en=1.
//  5 div_sel=7 with N_CH=3: no pend change, periods unaffected; rst asserted mid-run with
//    pend=3'b010: all outputs zero asynchronously, RST_DIVS restored.
//  6 CLK_TICK_SQ_EN set, div0=4: sq[0] toggles every 4 clk (period 8); unset: sq==0 always.

Source files
------------

// File: rtl/clk_tick_chain_pkg.sv
// clk_tick_pkg: shared constants for the clock-enable tick chain.
//   DEF_CNT_W     default counter/divisor width per stage
//   DEF_N_CH      default number of cascaded stages
//   DEF_RST_DIVS  default reset divisors (stage 0 in the LSB slice):
//                 100 MHz / 100 / 1000 / 1000 -> 1 MHz, 1 kHz, 1 Hz ticks
//   MAX_CH        largest supported number of stages
//   SEL_W         width of the divisor-write stage selector
package clk_tick_pkg;
    localparam int DEF_CNT_W = 17;
    localparam int DEF_N_CH  = 3;
    localparam int MAX_CH    = 8;
    localparam int SEL_W     = 3;
    localparam logic [DEF_N_CH*DEF_CNT_W-1:0] DEF_RST_DIVS =
        {17'd1000, 17'd1000, 17'd100};
endpackage

// File: rtl/clk_tick_chain_stage.sv
// clk_tick_stage: one divide stage of the tick chain.
//   Counts tick_in pulses and emits a one-cycle tick when the count reaches
//   the active divisor. A written divisor is held in a shadow register and only
//   becomes active on a wrap (or on a synchronous clear), so a period is never
//   cut short or stretched mid-count.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   tick_in       count qualifier (en for stage 0, previous stage tick otherwise)
//   sc            synchronous clear
//   wr, wval      divisor write strobe (already decoded for this stage) and value
//   tick          wrap pulse (combinational from registers and tick_in/sc)
//   pend          shadow divisor not yet active
//   sq            square output toggling on each tick (macro CLK_TICK_SQ_EN), else 0
module clk_tick_stage #(
    parameter int               CNT_W   = 17,
    parameter logic [CNT_W-1:0] RST_DIV = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             sc,
    input  logic             wr,
    input  logic [CNT_W-1:0] wval,
    output logic             tick,
    output logic             pend,
    output logic             sq
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] next_div;

    // Divisor 0 is treated like 1: wrap on every input.
    assign term     = (div == '0) ? '0 : div - CNT_W'(1);
    assign tick     = tick_in & ~sc & (cnt == term);
    // A write landing in the apply cycle takes effect immediately.
    assign next_div = wr ? wval : shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            div    <= RST_DIV;
            shadow <= RST_DIV;
            pend   <= 1'b0;
        end else if (sc) begin
            cnt    <= '0;
            div    <= next_div;
            shadow <= next_div;
            pend   <= 1'b0;
        end else begin
            if (tick_in)
                cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                div    <= next_div;
                shadow <= next_div;
                pend   <= 1'b0;
            end else if (wr) begin
                shadow <= wval;
                pend   <= 1'b1;
            end
        end
    end

`ifdef CLK_TICK_SQ_EN
    logic sq_q;
    // Cleared by rst only; sc leaves the phase alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sq_q <= 1'b0;
        else if (tick)
            sq_q <= ~sq_q;
    end
    assign sq = sq_q;
`else
    assign sq = 1'b0;
`endif
endmodule

// File: rtl/clk_tick_chain.sv
// clk_tick_chain: cascade of N_CH divide stages producing one-cycle clock
//   enables on the system clock instead of derived clocks. Stage k counts the
//   ticks of stage k-1; stage 0 counts clk cycles while en=1. Ticks are
//   combinational down the chain, so stages that wrap together pulse together.
// Optional feature: define CLK_TICK_SQ_EN to get 50%-duty square outputs.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   en            count enable for stage 0
//   sc            synchronous clear of all counters (priority over en/wraps)
//   div_wr        divisor write strobe; div_sel selects stage, div_val value
//   pend[k]       written divisor still waiting for stage k to wrap
//   tick[k]       one-cycle pulse each time stage k wraps
//   sq[k]         square output per stage (0 when feature disabled)
module clk_tick_chain
    import clk_tick_pkg::*;
#(
    parameter int                      N_CH     = DEF_N_CH,
    parameter int                      CNT_W    = DEF_CNT_W,
    parameter logic [N_CH*CNT_W-1:0]   RST_DIVS = (N_CH*CNT_W)'(DEF_RST_DIVS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sc,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [CNT_W-1:0] div_val,
    output logic [N_CH-1:0]  pend,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq
);
    logic [N_CH-1:0] stg_in;
    logic [N_CH-1:0] stg_wr;

    assign stg_in[0] = en & ~sc;

    for (genvar k = 0; k < N_CH; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign stg_in[k] = tick[k-1];
        end
        // Selectors at or above N_CH match no stage and are dropped.
        assign stg_wr[k] = div_wr & (div_sel == SEL_W'(k));

        clk_tick_stage #(
            .CNT_W   (CNT_W),
            .RST_DIV (RST_DIVS[k*CNT_W +: CNT_W])
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .tick_in (stg_in[k]),
            .sc      (sc),
            .wr      (stg_wr[k]),
            .wval    (div_val),
            .tick    (tick[k]),
            .pend    (pend[k]),
            .sq      (sq[k])
        );
    end
endmodule
